// File: rtl/reg_window_pkg.sv
// Shared types and constants for the register-window controller.
package reg_window_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SPILL,
      FILL
   } state_e;

   localparam logic MEM_DIR_SPILL = 1'b0;
   localparam logic MEM_DIR_FILL  = 1'b1;

   localparam int unsigned DEF_OP_PUSH0 = 11;
   localparam int unsigned DEF_OP_POP0  = 12;
   localparam int unsigned DEF_OP_PUSH1 = 13;
   localparam int unsigned DEF_OP_POP1  = 14;

endpackage

// File: rtl/reg_window_ctrl_if.sv
// Spill/fill request channel between the window controller and memory.
interface reg_window_ctrl_if #(
   parameter int unsigned BANK_BITS  = 6,
   parameter int unsigned DEPTH_BITS = 10
);
   logic                  mem_req_o;
   logic                  mem_dir_o;
   logic [BANK_BITS-1:0]  mem_bank_o;
   logic [DEPTH_BITS-1:0] mem_depth_o;
   logic                  mem_ack_i;

   modport master (
      output mem_req_o, mem_dir_o, mem_bank_o, mem_depth_o,
      input  mem_ack_i
   );

   modport slave (
      input  mem_req_o, mem_dir_o, mem_bank_o, mem_depth_o,
      output mem_ack_i
   );
endinterface

// File: rtl/reg_window_opdec.sv
// Combinational decode of the opcode into push/pop requests.
module reg_window_opdec #(
   parameter int unsigned OPCODE_W = 7,
   parameter int unsigned OP_PUSH0 = 11,
   parameter int unsigned OP_POP0  = 12,
   parameter int unsigned OP_PUSH1 = 13,
   parameter int unsigned OP_POP1  = 14
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output logic                is_push_o,
   output logic                is_pop_o
);

   always_comb begin
      is_push_o = (opcode_i == OPCODE_W'(OP_PUSH0)) || (opcode_i == OPCODE_W'(OP_PUSH1));
      is_pop_o  = (opcode_i == OPCODE_W'(OP_POP0))  || (opcode_i == OPCODE_W'(OP_POP1));
   end

endmodule

// File: rtl/reg_window_ctrl.sv
// Register-window controller: maps logical call depth onto physical banks,
// spilling the oldest window on overflow of the bank file and filling on underflow.
module reg_window_ctrl
   import reg_window_pkg::*;
#(
   parameter int unsigned BANK_BITS  = 6,
   parameter int unsigned DEPTH_BITS = 10,
   parameter int unsigned OPCODE_W   = 7,
   parameter int unsigned OP_PUSH0   = DEF_OP_PUSH0,
   parameter int unsigned OP_POP0    = DEF_OP_POP0,
   parameter int unsigned OP_PUSH1   = DEF_OP_PUSH1,
   parameter int unsigned OP_POP1    = DEF_OP_POP1
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  enable_i,
   input  logic [OPCODE_W-1:0]   opCode_i,
   output logic [BANK_BITS-1:0]  regBankSelect_o,
   output logic [DEPTH_BITS-1:0] depth_o,
   output logic                  busy_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   reg_window_ctrl_if.master     mem_if
);

   localparam int unsigned N     = 1 << BANK_BITS;
   localparam int unsigned RES_W = BANK_BITS + 1;
   localparam logic [RES_W-1:0]      RES_ONE   = RES_W'(1);
   localparam logic [RES_W-1:0]      RES_FULL  = RES_W'(N);
   localparam logic [DEPTH_BITS-1:0] DEPTH_ONE = DEPTH_BITS'(1);
   localparam logic [DEPTH_BITS-1:0] DEPTH_N   = DEPTH_BITS'(N);
   localparam logic [DEPTH_BITS-1:0] DEPTH_MAX = '1;

   state_e                state_q, state_d;
   logic [DEPTH_BITS-1:0] depth_q, depth_d;
   logic [RES_W-1:0]      resident_q, resident_d;
   logic                  dir_q, dir_d;
   logic [BANK_BITS-1:0]  bank_q, bank_d;
   logic [DEPTH_BITS-1:0] mdepth_q, mdepth_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;

   logic                  is_push, is_pop;
   logic [DEPTH_BITS-1:0] depth_inc, depth_dec;

   reg_window_opdec #(
      .OPCODE_W (OPCODE_W),
      .OP_PUSH0 (OP_PUSH0),
      .OP_POP0  (OP_POP0),
      .OP_PUSH1 (OP_PUSH1),
      .OP_POP1  (OP_POP1)
   ) u_opdec (
      .opcode_i  (opCode_i),
      .is_push_o (is_push),
      .is_pop_o  (is_pop)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         depth_q    <= '0;
         resident_q <= RES_ONE;
         dir_q      <= MEM_DIR_SPILL;
         bank_q     <= '0;
         mdepth_q   <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         depth_q    <= depth_d;
         resident_q <= resident_d;
         dir_q      <= dir_d;
         bank_q     <= bank_d;
         mdepth_q   <= mdepth_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // Depth change of a spill/fill is deferred until the ack; resident count stays put.
   always_comb begin
      depth_inc  = depth_q + DEPTH_ONE;
      depth_dec  = depth_q - DEPTH_ONE;
      state_d    = state_q;
      depth_d    = depth_q;
      resident_d = resident_q;
      dir_d      = dir_q;
      bank_d     = bank_q;
      mdepth_d   = mdepth_q;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable_i && is_push) begin
               if (depth_q == DEPTH_MAX) begin
                  ovf_d = 1'b1;
               end else if (resident_q != RES_FULL) begin
                  depth_d    = depth_inc;
                  resident_d = resident_q + RES_ONE;
               end else begin
                  state_d  = SPILL;
                  dir_d    = MEM_DIR_SPILL;
                  bank_d   = depth_inc[BANK_BITS-1:0];
                  mdepth_d = depth_inc - DEPTH_N;
               end
            end else if (enable_i && is_pop) begin
               if (depth_q == '0) begin
                  unf_d = 1'b1;
               end else if (resident_q != RES_ONE) begin
                  depth_d    = depth_dec;
                  resident_d = resident_q - RES_ONE;
               end else begin
                  state_d  = FILL;
                  dir_d    = MEM_DIR_FILL;
                  bank_d   = depth_dec[BANK_BITS-1:0];
                  mdepth_d = depth_dec;
               end
            end
         end
         SPILL: begin
            if (mem_if.mem_ack_i) begin
               depth_d = depth_inc;
               state_d = IDLE;
            end
         end
         FILL: begin
            if (mem_if.mem_ack_i) begin
               depth_d = depth_dec;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o             = (state_q != IDLE);
      mem_if.mem_req_o   = (state_q != IDLE);
      mem_if.mem_dir_o   = dir_q;
      mem_if.mem_bank_o  = bank_q;
      mem_if.mem_depth_o = mdepth_q;
      regBankSelect_o    = depth_q[BANK_BITS-1:0];
      depth_o            = depth_q;
      overflow_o         = ovf_q;
      underflow_o        = unf_q;
   end

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Bench for reg_window_ctrl: directed vector table, overflow walk, and
// randomized traffic checked against a window-queue reference model.
module tb_reg_window_ctrl;

   localparam int BB   = 2;
   localparam int DB   = 4;
   localparam int OW   = 7;
   localparam int N    = 4;
   localparam int MAXD = 15;

   logic          clk = 1'b0;
   logic          rst, en, ack;
   logic [OW-1:0] op;
   logic [BB-1:0] bank_sel;
   logic [DB-1:0] depth;
   logic          busy, ovf, unf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_window_ctrl_if #(.BANK_BITS(BB), .DEPTH_BITS(DB)) mif ();
   assign mif.mem_ack_i = ack;

   reg_window_ctrl #(
      .BANK_BITS  (BB),
      .DEPTH_BITS (DB),
      .OPCODE_W   (OW)
   ) dut (
      .clock_i         (clk),
      .reset_i         (rst),
      .enable_i        (en),
      .opCode_i        (op),
      .regBankSelect_o (bank_sel),
      .depth_o         (depth),
      .busy_o          (busy),
      .overflow_o      (ovf),
      .underflow_o     (unf),
      .mem_if          (mif)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int d, input int b, input int bz,
                            input int dir, input int mb, input int md, input int ov, input int un);
      chk({tag, ".depth"},     32'(depth),           d);
      chk({tag, ".bank_sel"},  32'(bank_sel),        b);
      chk({tag, ".busy"},      32'(busy),            bz);
      chk({tag, ".mem_req"},   32'(mif.mem_req_o),   bz);
      chk({tag, ".mem_dir"},   32'(mif.mem_dir_o),   dir);
      chk({tag, ".mem_bank"},  32'(mif.mem_bank_o),  mb);
      chk({tag, ".mem_depth"}, 32'(mif.mem_depth_o), md);
      chk({tag, ".overflow"},  32'(ovf),             ov);
      chk({tag, ".underflow"}, 32'(unf),             un);
   endtask

   task automatic drive(input logic r, input logic e, input logic [OW-1:0] o, input logic a);
      rst = r; en = e; op = o; ack = a;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          rst, en, ack;
      logic [OW-1:0] op;
      int            d, b, bz, dir, mb, md, ov, un;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic e, input logic [OW-1:0] o, input logic a,
                               input int d, input int b, input int bz, input int dir,
                               input int mb, input int md, input int ov, input int un);
      vec_t v;
      v.rst = r; v.en = e; v.op = o; v.ack = a;
      v.d = d; v.b = b; v.bz = bz; v.dir = dir; v.mb = mb; v.md = md; v.ov = ov; v.un = un;
      tbl.push_back(v);
   endfunction

   // Reference model: the resident windows are an ordered list of logical indices.
   int m_win[$];
   int m_d, m_x, m_xw, m_dir, m_ov, m_un;

   task automatic model(input logic r, input logic e, input logic [OW-1:0] o, input logic a);
      bit push, pop;
      push = (o == 11) || (o == 13);
      pop  = (o == 12) || (o == 14);
      m_ov = 0; m_un = 0;
      if (r) begin
         m_win = {0};
         m_d = 0; m_x = 0; m_xw = 0; m_dir = 0;
      end else if (m_x == 1) begin
         if (a) begin
            void'(m_win.pop_front());
            m_d = m_d + 1;
            m_win.push_back(m_d);
            m_x = 0;
         end
      end else if (m_x == 2) begin
         if (a) begin
            void'(m_win.pop_back());
            m_d = m_d - 1;
            m_win.push_front(m_d);
            m_x = 0;
         end
      end else if (e && push) begin
         if (m_d == MAXD) m_ov = 1;
         else if (m_win.size() < N) begin
            m_d = m_d + 1;
            m_win.push_back(m_d);
         end else begin
            m_x = 1; m_dir = 0; m_xw = m_win[0];
         end
      end else if (e && pop) begin
         if (m_d == 0) m_un = 1;
         else if (m_win.size() > 1) begin
            void'(m_win.pop_back());
            m_d = m_d - 1;
         end else begin
            m_x = 2; m_dir = 1; m_xw = m_d - 1;
         end
      end
   endtask

   initial begin
      bit up;
      int k;
      logic r, e, a;
      logic [OW-1:0] o;

      rst = 1'b1; en = 1'b0; op = '0; ack = 1'b0;

      //    rst en  op  ack   d  b bz dir mb md ov un
      add(1, 0,  0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 11, 0,    1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 11, 0,    2, 2, 0, 0, 0, 0, 0, 0);
      add(0, 1, 11, 0,    3, 3, 0, 0, 0, 0, 0, 0);
      add(0, 1, 13, 0,    3, 3, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         add(0, 1, 11, 0, 3, 3, 1, 0, 0, 0, 0, 0);
      add(0, 1, 11, 1,    4, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1,  0, 0,    4, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0,  0, 1,    4, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 12, 0,    3, 3, 0, 0, 0, 0, 0, 0);
      add(0, 1, 14, 0,    2, 2, 0, 0, 0, 0, 0, 0);
      add(0, 1, 12, 0,    1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 12, 0,    1, 1, 1, 1, 0, 0, 0, 0);
      add(0, 0,  0, 1,    0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 12, 0,    0, 0, 0, 1, 0, 0, 0, 1);
      add(0, 0,  0, 0,    0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 0, 11, 0,    0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 0, 13, 0,    0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 15, 0,    0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 11, 0,    1, 1, 0, 1, 0, 0, 0, 0);
      add(0, 1, 11, 0,    2, 2, 0, 1, 0, 0, 0, 0);
      add(0, 1, 11, 0,    3, 3, 0, 1, 0, 0, 0, 0);
      add(0, 1, 11, 0,    3, 3, 1, 0, 0, 0, 0, 0);
      add(1, 1, 11, 1,    0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0,  0, 1,    0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 13, 0,    1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 14, 0,    0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 14, 0,    0, 0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].op, tbl[i].ack);
         check_all($sformatf("vec%0d", i), tbl[i].d, tbl[i].b, tbl[i].bz, tbl[i].dir,
                   tbl[i].mb, tbl[i].md, tbl[i].ov, tbl[i].un);
      end

      // Walk up to maximum depth, acknowledging each spill, then push once more.
      drive(1, 0, 0, 0);
      for (int i = 0; i < MAXD; i++) begin
         drive(0, 1, 11, 0);
         if (i >= N - 1) begin
            check_all($sformatf("walk_spill%0d", i), i, i % N, 1, 0, (i + 1) % N, i + 1 - N, 0, 0);
            drive(0, 0, 0, 1);
         end
         chk($sformatf("walk_depth%0d", i), 32'(depth), i + 1);
         chk($sformatf("walk_busy%0d", i), 32'(busy), 0);
      end
      drive(0, 1, 13, 0);
      chk("ovf_pulse", 32'(ovf), 1);
      chk("ovf_depth", 32'(depth), MAXD);
      chk("ovf_busy", 32'(busy), 0);
      drive(0, 0, 0, 0);
      chk("ovf_clear", 32'(ovf), 0);
      chk("ovf_depth_hold", 32'(depth), MAXD);

      // Randomized traffic, alternating push-heavy and pop-heavy phases.
      up = 1'b0;
      drive(1, 0, 0, 0);
      model(1, 0, 0, 0);
      for (int c = 0; c < 4000; c++) begin
         if (c % 150 == 0) up = !up;
         r = ($urandom_range(0, 399) == 0);
         e = ($urandom_range(0, 3) != 0);
         k = $urandom_range(0, 9);
         if (k < 6)      o = up ? ((k % 2 != 0) ? OW'(11) : OW'(13)) : ((k % 2 != 0) ? OW'(12) : OW'(14));
         else if (k < 8) o = up ? OW'(12) : OW'(11);
         else            o = OW'($urandom_range(0, 127));
         a = ($urandom_range(0, 2) == 0);
         drive(r, e, o, a);
         model(r, e, o, a);
         check_all($sformatf("rnd%0d", c), m_d, m_d % N, (m_x != 0) ? 1 : 0, m_dir,
                   m_xw % N, m_xw, m_ov, m_un);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_window_ctrl.md
Name: reg_window_ctrl

Overview:
- Register-window controller for the decode stage.
- Tracks a logical call depth and maps it onto 2^BANK_BITS physical register banks.
- When all physical banks are occupied, spills the oldest window to memory before a push completes; when the last resident window is popped, fills the caller's window back before the pop completes.
- Drives the bank select to the register file and a spill/fill request to the memory interface. Stalls the front end with busy_o while a transfer is outstanding.

Parameters:
- BANK_BITS, 6, log2 of the physical bank count; N = 2^BANK_BITS.
- DEPTH_BITS, 10, width of the logical depth counter; maximum depth is 2^DEPTH_BITS-1.
- OPCODE_W, 7, opcode width.
- OP_PUSH0, 11, push opcode A.
- OP_POP0, 12, pop opcode A.
- OP_PUSH1, 13, push opcode B.
- OP_POP1, 14, pop opcode B.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  the opcode is valid this cycle.
- opCode_i  in  OPCODE_W  decoded opcode.
- regBankSelect_o  out  BANK_BITS  current physical bank, equal to depth mod N.
- depth_o  out  DEPTH_BITS  current logical depth.
- busy_o  out  1  a transfer is in progress; opcodes are ignored while high.
- mem_req_o  out  1  spill/fill request, held until acknowledged.
- mem_dir_o  out  1  0 = spill (bank to memory), 1 = fill (memory to bank).
- mem_bank_o  out  BANK_BITS  physical bank being transferred.
- mem_depth_o  out  DEPTH_BITS  logical window index being transferred.
- mem_ack_i  in  1  transfer complete, single-cycle pulse.
- overflow_o  out  1  one-cycle pulse: push attempted at maximum depth.
- underflow_o  out  1  one-cycle pulse: pop attempted at depth 0.

Behaviour:
- Internal state:
  - depth_q, DEPTH_BITS wide.
  - resident_q, range 1..N: number of windows held in physical banks.
  - FSM with states IDLE, SPILL, FILL.
- Reset values:
  - depth_q = 0, resident_q = 1, state = IDLE.
  - All outputs are 0.
  - Reset has priority over every other input, including in SPILL/FILL: mem_req_o drops on the cycle after reset is sampled, and an in-flight ack is discarded.
- All outputs are registered. regBankSelect_o and depth_o reflect an accepted op on the cycle after it is sampled (1-cycle latency).
- An op is accepted only when enable_i=1 and state=IDLE. Any opcode other than the four push/pop codes is a no-op.
- Push in IDLE:
  - depth_q == max: pulse overflow_o; no state change.
  - resident_q < N: depth_q+1 and resident_q+1.
  - resident_q == N: go to SPILL. Drive mem_dir_o=0, mem_bank_o=(depth_q+1) mod N (the oldest resident window), mem_depth_o=depth_q+1-N. mem_req_o=1 and busy_o=1 from the next cycle.
- Pop in IDLE:
  - depth_q == 0: pulse underflow_o; no change.
  - resident_q > 1: depth_q-1 and resident_q-1.
  - resident_q == 1: go to FILL. Drive mem_dir_o=1, mem_bank_o=(depth_q-1) mod N, mem_depth_o=depth_q-1, mem_req_o=1, busy_o=1.
- SPILL/FILL states:
  - mem_req_o, mem_bank_o, mem_depth_o and mem_dir_o stay stable until mem_ack_i.
  - On ack: apply the deferred depth change (SPILL: +1; FILL: -1); resident_q is unchanged; clear mem_req_o and busy_o; return to IDLE. The new depth is visible on the next cycle.
  - Ack and an incoming opcode in the same cycle: the opcode is ignored, because busy is still high.
- mem_ack_i outside SPILL/FILL is ignored.
- Bank index wraps modulo N. depth_q never wraps: it saturates via the overflow and underflow checks.

Decomposition:
- Shared package, reg_window_pkg:
  - state enum {IDLE, SPILL, FILL};
  - MEM_DIR_SPILL = 0 and MEM_DIR_FILL = 1;
  - the four default opcode constants.
- One sub-module: reg_window_opdec, a combinational decode of opCode_i into is_push/is_pop.
- All remaining logic lives in reg_window_ctrl.

Test Plan (BANK_BITS=2, N=4, DEPTH_BITS=4 unless stated):
- Reset, then 3 pushes (opcode 11) -> regBankSelect_o 1, 2, 3, each one cycle after its op; busy_o stays 0; resident_q = 4.
- A 4th push (opcode 13) -> mem_req_o=1, mem_dir_o=0, mem_bank_o=0, mem_depth_o=0, busy_o=1. Hold mem_ack_i=0 for 5 cycles while pushing: req stays stable and depth_o stays 3. Pulse ack -> depth_o=4, regBankSelect_o=0, busy_o=0.
- From depth 4 with resident_q=4, 3 pops -> depth 1, no memory request. A 4th pop -> FILL with mem_dir_o=1, mem_bank_o=0, mem_depth_o=0. After ack -> depth_o=0, regBankSelect_o=0.
- Pop at depth 0 -> underflow_o high for exactly 1 cycle; all other outputs unchanged. Push to depth 15, then push again -> overflow_o pulse; depth_o stays 15.
- Assert reset_i during SPILL -> next cycle mem_req_o=0, busy_o=0, depth_o=0; a later ack pulse has no effect.
- With enable_i=0, opcodes 11-14 have no effect. With enable_i=1, opcode 0 or 15 has no effect. A stray mem_ack_i in IDLE is ignored.
